// File: rtl/axi_lite_rr_arbiter_pkg.sv
// axi_lite_arb_pkg: state encoding, AXI response codes and index-width helper for the arbiter
package axi_lite_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP} arb_state_e;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_lite_rr_arbiter_if.sv
// axi_lite_rr_arbiter_if: per-master AXI4-Lite ports plus the shared slave port
interface axi_lite_rr_arbiter_if #(
  parameter int NUM_M = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_M*ADDR_W-1:0]     s_awaddr;
  logic [NUM_M-1:0]            s_awvalid, s_awready;
  logic [NUM_M*DATA_W-1:0]     s_wdata;
  logic [NUM_M*(DATA_W/8)-1:0] s_wstrb;
  logic [NUM_M-1:0]            s_wvalid, s_wready;
  logic [1:0]                  s_bresp;
  logic [NUM_M-1:0]            s_bvalid, s_bready;
  logic [NUM_M*ADDR_W-1:0]     s_araddr;
  logic [NUM_M-1:0]            s_arvalid, s_arready;
  logic [DATA_W-1:0]           s_rdata;
  logic [1:0]                  s_rresp;
  logic [NUM_M-1:0]            s_rvalid, s_rready;
  logic [ADDR_W-1:0]           m_awaddr;
  logic                        m_awvalid, m_awready;
  logic [DATA_W-1:0]           m_wdata;
  logic [DATA_W/8-1:0]         m_wstrb;
  logic                        m_wvalid, m_wready;
  logic [1:0]                  m_bresp;
  logic                        m_bvalid, m_bready;
  logic [ADDR_W-1:0]           m_araddr;
  logic                        m_arvalid, m_arready;
  logic [DATA_W-1:0]           m_rdata;
  logic [1:0]                  m_rresp;
  logic                        m_rvalid, m_rready;
  modport master (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
  );
  modport slave (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/axi_lite_rr_arbiter_rr_pick.sv
// rr_pick: first requester at or after ptr, wrapping, as one-hot and binary index
module rr_pick
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  localparam int IW = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);
  // scan from ptr upward modulo NUM_M and keep the first hit
  always_comb begin
    logic [IW-1:0] j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_M; i++) begin
      j = IW'((int'(ptr_i) + i) % NUM_M);
      if (req_i[j] && !found) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: round-robin sharing of one AXI4-Lite slave, one transaction at a time
module axi_lite_rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axi_lite_rr_arbiter_if.master bus,
  output logic [NUM_M-1:0]      grant,
  output logic                  busy
);
  localparam int IW = idx_w(NUM_M);
  localparam int SW = DATA_W / 8;
  arb_state_e state_q;
  logic [NUM_M-1:0] grant_q, req, pick_gnt;
  logic [IW-1:0] gidx_q, ptr_q, ptr_d, pick_idx;
  logic aw_done_q, w_done_q;
  logic st_wa, st_wr, st_ra, st_rr;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign req = bus.s_awvalid | bus.s_arvalid;
  assign ptr_d = (int'(gidx_q) == NUM_M - 1) ? '0 : gidx_q + 1'b1;
  assign st_wa = state_q == WR_ADDR;
  assign st_wr = state_q == WR_RESP;
  assign st_ra = state_q == RD_ADDR;
  assign st_rr = state_q == RD_RESP;
  assign aw_fire = bus.m_awvalid && bus.m_awready;
  assign w_fire = bus.m_wvalid && bus.m_wready;
  assign b_fire = bus.m_bvalid && bus.m_bready;
  assign ar_fire = bus.m_arvalid && bus.m_arready;
  assign r_fire = bus.m_rvalid && bus.m_rready;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  // route the granted master to the slave; everything gated by state so reset silences it at once
  always_comb begin
    bus.m_awaddr  = st_wa ? bus.s_awaddr[int'(gidx_q)*ADDR_W +: ADDR_W] : '0;
    bus.m_awvalid = st_wa && !aw_done_q && bus.s_awvalid[gidx_q];
    bus.m_wdata   = st_wa ? bus.s_wdata[int'(gidx_q)*DATA_W +: DATA_W] : '0;
    bus.m_wstrb   = st_wa ? bus.s_wstrb[int'(gidx_q)*SW +: SW] : '0;
    bus.m_wvalid  = st_wa && !w_done_q && bus.s_wvalid[gidx_q];
    bus.m_bready  = st_wr && bus.s_bready[gidx_q];
    bus.m_araddr  = st_ra ? bus.s_araddr[int'(gidx_q)*ADDR_W +: ADDR_W] : '0;
    bus.m_arvalid = st_ra && bus.s_arvalid[gidx_q];
    bus.m_rready  = st_rr && bus.s_rready[gidx_q];
    bus.s_awready = (st_wa && !aw_done_q && bus.m_awready) ? grant_q : '0;
    bus.s_wready  = (st_wa && !w_done_q && bus.m_wready) ? grant_q : '0;
    bus.s_bvalid  = (st_wr && bus.m_bvalid) ? grant_q : '0;
    bus.s_arready = (st_ra && bus.m_arready) ? grant_q : '0;
    bus.s_rvalid  = (st_rr && bus.m_rvalid) ? grant_q : '0;
    bus.s_bresp   = bus.m_bresp;
    bus.s_rdata   = bus.m_rdata;
    bus.s_rresp   = bus.m_rresp;
  end
  // transaction FSM: grant in IDLE, hold until the response handshake, then advance the pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          grant_q <= pick_gnt;
          gidx_q  <= pick_idx;
          state_q <= bus.s_awvalid[pick_idx] ? WR_ADDR : RD_ADDR;
        end
        WR_ADDR: if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_q   <= WR_RESP;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_done_q || aw_fire;
          w_done_q  <= w_done_q || w_fire;
        end
        WR_RESP: if (b_fire) begin
          ptr_q   <= ptr_d;
          grant_q <= '0;
          state_q <= IDLE;
        end
        RD_ADDR: if (ar_fire) state_q <= RD_RESP;
        RD_RESP: if (r_fire) begin
          ptr_q   <= ptr_d;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb_axi_lite_rr_arbiter: directed vector table plus hand sequences for the round-robin arbiter
module tb_axi_lite_rr_arbiter;
  import axi_lite_arb_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] grant;
  logic busy;
  logic [3:0] grant4;
  logic busy4;
  int n_vec = 0;
  int n_bad = 0;
  axi_lite_rr_arbiter_if #(.NUM_M(2)) bus ();
  axi_lite_rr_arbiter_if #(.NUM_M(4)) bus4 ();
  axi_lite_rr_arbiter #(.NUM_M(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus), .grant(grant), .busy(busy));
  axi_lite_rr_arbiter #(.NUM_M(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4), .grant(grant4), .busy(busy4));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0]  awv, wv, arv;
    logic [1:0]  gnt;
    logic        bsy;
    logic [2:0]  mv;
    logic [1:0]  awr, wr, arr, bv, rv;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
  } vec_t;
  vec_t tbl [22];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[1]  = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 3'b110, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 12'h010, 32'hDEADBEEF, 4'hF};
    tbl[2]  = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[3]  = '{2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[4]  = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 3'b110, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 12'h020, 32'hCAFE0001, 4'h3};
    tbl[5]  = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[6]  = '{2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[7]  = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 3'b001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 12'h104, 32'h0, 4'h0};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 12'h000, 32'h0, 4'h0};
    tbl[9]  = '{2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[10] = '{2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 3'b001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 12'h100, 32'h0, 4'h0};
    tbl[11] = '{2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 12'h000, 32'h0, 4'h0};
    tbl[12] = '{2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[13] = '{2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 3'b001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 12'h104, 32'h0, 4'h0};
    tbl[14] = '{2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 12'h000, 32'h0, 4'h0};
    tbl[15] = '{2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[16] = '{2'b00, 2'b00, 2'b11, 2'b01, 1'b1, 3'b001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 12'h100, 32'h0, 4'h0};
    tbl[17] = '{2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 12'h000, 32'h0, 4'h0};
    tbl[18] = '{2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    tbl[19] = '{2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 3'b001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 12'h104, 32'h0, 4'h0};
    tbl[20] = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 12'h000, 32'h0, 4'h0};
    tbl[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 32'h0, 4'h0};
    bus.s_awaddr = {32'h20, 32'h10};
    bus.s_wdata = {32'hCAFE0001, 32'hDEADBEEF};
    bus.s_wstrb = {4'h3, 4'hF};
    bus.s_araddr = {32'h104, 32'h100};
    bus.s_awvalid = '0;
    bus.s_wvalid = '0;
    bus.s_arvalid = '0;
    bus.s_bready = 2'b11;
    bus.s_rready = 2'b11;
    bus.m_awready = 1'b1;
    bus.m_wready = 1'b1;
    bus.m_bvalid = 1'b1;
    bus.m_bresp = OKAY;
    bus.m_arready = 1'b1;
    bus.m_rvalid = 1'b1;
    bus.m_rdata = 32'h12345678;
    bus.m_rresp = OKAY;
    bus4.s_awaddr = '0;
    bus4.s_wdata = '0;
    bus4.s_wstrb = '0;
    bus4.s_araddr = {32'h300, 32'h200, 32'h100, 32'h000};
    bus4.s_awvalid = '0;
    bus4.s_wvalid = '0;
    bus4.s_arvalid = '0;
    bus4.s_bready = 4'hF;
    bus4.s_rready = 4'hF;
    bus4.m_awready = 1'b1;
    bus4.m_wready = 1'b1;
    bus4.m_bvalid = 1'b1;
    bus4.m_bresp = OKAY;
    bus4.m_arready = 1'b1;
    bus4.m_rvalid = 1'b1;
    bus4.m_rdata = 32'h0;
    bus4.m_rresp = OKAY;
    #2;
    chk("reset_state", {grant, busy, bus.s_bvalid, bus.s_rvalid, bus.m_bready, bus.m_rready}, 8'h00);
    step();
    step();
    reset_n = 1'b1;
    // write m0, write+read m1, then four contended reads alternating 0,1,0,1
    for (int i = 0; i < 22; i++) begin
      bus.s_awvalid = tbl[i].awv;
      bus.s_wvalid = tbl[i].wv;
      bus.s_arvalid = tbl[i].arv;
      #1;
      chk($sformatf("vec%0d", i),
          {grant, busy, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.s_awready, bus.s_wready, bus.s_arready,
           bus.s_bvalid, bus.s_rvalid, bus.m_awaddr | bus.m_araddr, bus.m_wdata, bus.m_wstrb},
          {tbl[i].gnt, tbl[i].bsy, tbl[i].mv, tbl[i].awr, tbl[i].wr, tbl[i].arr, tbl[i].bv, tbl[i].rv,
           20'h0, tbl[i].addr, tbl[i].wd, tbl[i].st});
      @(posedge clk);
      #1;
    end
    // W accepted two cycles before AW
    bus.m_awready = 1'b0;
    bus.s_awvalid = 2'b01;
    bus.s_wvalid = 2'b01;
    step();
    chk("t3_both_valid", {bus.m_awvalid, bus.m_wvalid, bus.s_awready, bus.s_wready}, {1'b1, 1'b1, 2'b00, 2'b01});
    chk("t3_wdata", {bus.m_wdata, bus.m_wstrb, bus.m_awaddr}, {32'hDEADBEEF, 4'hF, 32'h10});
    step();
    bus.s_wvalid = 2'b00;
    #1;
    chk("t3_w_dropped", {bus.m_awvalid, bus.m_wvalid, bus.s_wready, bus.s_bvalid, busy}, {1'b1, 1'b0, 2'b00, 2'b00, 1'b1});
    step();
    bus.m_awready = 1'b1;
    #1;
    chk("t3_aw_pending", {bus.m_awvalid, bus.s_awready, bus.s_bvalid, bus.m_wvalid}, {1'b1, 2'b01, 2'b00, 1'b0});
    step();
    bus.s_awvalid = 2'b00;
    bus.m_bresp = SLVERR;
    #1;
    chk("t3_wr_resp", {bus.s_bvalid, bus.m_bready, bus.s_bresp}, {2'b01, 1'b1, SLVERR});
    step();
    bus.m_bresp = OKAY;
    // read by m1 interrupted by reset while the response is pending
    bus.m_rvalid = 1'b0;
    bus.s_arvalid = 2'b10;
    step();
    chk("t5_rd_addr", {grant, bus.s_arready, bus.m_araddr}, {2'b10, 2'b10, 32'h104});
    step();
    bus.s_arvalid = 2'b00;
    #1;
    chk("t5_rd_wait", {busy, bus.s_rvalid, bus.m_rready}, {1'b1, 2'b00, 1'b1});
    bus.m_rvalid = 1'b1;
    #1;
    chk("t5_rdata", {bus.s_rvalid, bus.s_rdata, bus.s_rresp}, {2'b10, 32'h12345678, OKAY});
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_async_reset",
        {busy, grant, bus.m_rready, bus.s_rvalid, bus.m_arvalid, bus.s_arready, bus.m_awvalid, bus.m_wvalid,
         bus.m_bready, bus.s_awready, bus.s_wready, bus.s_bvalid}, 17'h0);
    step();
    step();
    reset_n = 1'b1;
    bus.s_arvalid = 2'b11;
    #1;
    chk("t5_idle_after_reset", {grant, busy}, 3'b000);
    step();
    chk("t5_ptr_reset", {grant, bus.m_araddr}, {2'b01, 32'h100});
    step();
    bus.s_arvalid = 2'b10;
    step();
    step();
    chk("t5_next_m1", {grant, bus.m_araddr}, {2'b10, 32'h104});
    step();
    bus.s_arvalid = 2'b00;
    step();
    // four masters, master 3 requesting continuously
    bus4.s_arvalid = 4'b1000;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t6_cyc%0d", k), {grant4, busy4, bus4.s_arready, bus4.s_rvalid, bus4.m_araddr},
          (k % 3 == 0) ? {4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0} :
          (k % 3 == 1) ? {4'b1000, 1'b1, 4'b1000, 4'b0000, 32'h300} :
                         {4'b1000, 1'b1, 4'b0000, 4'b1000, 32'h0});
      if (k == 8) bus4.s_arvalid = 4'b1010;
      step();
    end
    chk("t6_idle", {grant4, busy4}, 5'b00000);
    step();
    chk("t6_ptr_wrapped", {grant4, bus4.m_araddr}, {4'b0010, 32'h100});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
